mab_access_ctrl: RTL and testbench
==================================

# mab_access_ctrl

Per-instruction memory-access sequencer for the MSP430 core. It walks each instruction through fetch, extension-word, operand-read, write-back, push and RETI-pop phases. It drives the MAB address-source select (MAB_sel), the memory read and write strobes, and the PC/SP step controls. It sits between the instruction decoder and the MAB multiplexer and is the only block that drives MAB_sel.

## Interface
No parameters.
- clk  in  1  core clock; all state changes on posedge
- rst  in  1  asynchronous, active-high reset
- run  in  1  level; 1 = keep issuing instructions
- op_fmt  in  2  0 double-operand, 1 single-operand, 2 jump, 3 RETI; valid from DECODE until done
- src_ext  in  1  source/single operand needs an extension word
- src_mem  in  1  source/single operand is read from memory
- src_ind  in  1  operand address comes from Sout (@Rn, @Rn+); 0 = from CALC_out (indexed/absolute/symbolic)
- dst_ext  in  1  double-op destination needs an extension word
- dst_mem  in  1  double-op destination is memory (read-modify-write)
- wb_mem  in  1  single-op result is written back to memory (ignored unless op_fmt=1)
- op_push  in  1  single-op is PUSH/CALL
- CALC_done  in  1  address calculator output is valid
- mem_ready  in  1  memory completes the current access this cycle
- MAB_sel  out  3  0 PC, 1 Sout, 2 CALC_out, 3 SP, 4 MDB_out
- mem_rd  out  1  read strobe
- mem_wr  out  1  write strobe
- pc_inc  out  1  PC += 2 this cycle
- sp_dec  out  1  SP -= 2 this cycle
- sp_inc  out  1  SP += 2 this cycle
- ir_load  out  1  latch MDB into the instruction register
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse; instruction retired

## Operation
- Moore FSM; all outputs decode from state (plus mem_ready/CALC_done for the step strobes). Outputs not listed for a state are 0, and MAB_sel defaults to 0.
- Reset: state IDLE; every output 0; MAB_sel=0.
- IDLE: if run, go to FETCH.
- FETCH: sel 0, mem_rd. On ready: pc_inc, ir_load, go to DECODE.
- DECODE: one cycle, no access. Branches on op_fmt and the mode bits:
  - jump → EXEC
  - RETI → POP_SR
  - otherwise → SRC_EXT if src_ext, else SRC_RD if src_mem, else DST_EXT/DST_RD/EXEC per the destination rules.
- SRC_EXT: sel 0, mem_rd. On ready: pc_inc, then go to SRC_RD if src_mem, else continue to the destination phase.
- SRC_RD: sel 1 if src_ind, else sel 2.
  - With sel 2, mem_rd is held low until CALC_done=1.
  - Advance on mem_ready while mem_rd is asserted.
- Destination phase (double-op only): DST_EXT (same as SRC_EXT) if dst_ext, then DST_RD (sel 2, gated on CALC_done) if dst_mem, then EXEC.
- EXEC: one cycle, no access. sp_dec if op_fmt=1 and op_push. Next state:
  - PUSH_WR if push
  - DST_WR if (fmt 0 and dst_mem) or (fmt 1 and wb_mem)
  - DONE otherwise
- DST_WR: mem_wr. MAB_sel is 2 for double-op; for single-op it equals the SRC_RD select. Advance on ready.
- PUSH_WR: sel 3, mem_wr. Advance on ready.
- POP_SR, then POP_PC: sel 3, mem_rd. Each asserts sp_inc on ready. POP_PC → DONE.
- DONE: done=1. Go to FETCH if run, else IDLE.
- The select value never changes while mem_rd or mem_wr is asserted.
- mem_rd and mem_wr are never both 1.

## Timing
- Each access state lasts ≥1 cycle and exits on the posedge where mem_ready=1.
- pc_inc, sp_inc and ir_load are asserted only in the completing cycle.
- Cycle counts with zero wait states:
  - register-to-register double-op: FETCH, DECODE, EXEC, DONE = 4 cycles
  - jump: 4 cycles
  - RETI: 5 cycles
- CALC_done low stalls SRC_RD/DST_RD indefinitely with sel 2 and mem_rd=0.
- mem_ready is ignored in non-access states.
- run dropping mid-instruction: the current instruction completes, then the FSM goes to IDLE.
- rst mid-access: immediate return to IDLE and all strobes drop asynchronously.

## Configuration
- MAB_WAIT_STATE_EN defined: mem_ready is honoured as described above.
- Not defined: mem_ready is treated as constant 1, so every access completes in one cycle. CALC_done gating remains.

## Test plan
- Reset during FETCH with mem_ready=0 → mem_rd, busy and MAB_sel fall to 0 without a clock edge; after rst release with run=1, FETCH starts on the next edge.
- Register-to-register double-op, run=1 → MAB_sel 0 for one cycle, pc_inc once, done at cycle 4, FETCH again at cycle 5.
- Indexed source (src_ext=1, src_mem=1, src_ind=0), CALC_done low for 3 cycles in SRC_RD → pc_inc twice in total, mem_rd low for 3 cycles at sel 2, then read.
- Indexed double-op to memory destination (dst_ext=1, dst_mem=1), then to EXEC → DST_WR at sel 2; mem_wr high for one cycle; no cycle has mem_rd and mem_wr both high.
- PUSH (op_fmt=1, op_push=1) → sp_dec in EXEC, then PUSH_WR at sel 3 with mem_wr.
- RETI with 2 wait states per pop → sel 3 for 6 cycles, sp_inc exactly twice, done pulse at the end; with MAB_WAIT_STATE_EN undefined the same instruction takes 5 cycles.

Source files
------------

// File: rtl/mab_access_ctrl.sv
// mab_access_ctrl: MSP430 per-instruction memory-access sequencer, sole driver of MAB_sel.
// Define MAB_WAIT_STATE_EN to honour mem_ready; otherwise every access completes in one cycle.
module mab_access_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [1:0] op_fmt,
    input  logic       src_ext,
    input  logic       src_mem,
    input  logic       src_ind,
    input  logic       dst_ext,
    input  logic       dst_mem,
    input  logic       wb_mem,
    input  logic       op_push,
    input  logic       CALC_done,
    input  logic       mem_ready,
    output logic [2:0] MAB_sel,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       pc_inc,
    output logic       sp_dec,
    output logic       sp_inc,
    output logic       ir_load,
    output logic       busy,
    output logic       done
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_SRC_EXT,
        S_SRC_RD,
        S_DST_EXT,
        S_DST_RD,
        S_EXEC,
        S_DST_WR,
        S_PUSH_WR,
        S_POP_SR,
        S_POP_PC,
        S_DONE
    } state_e;

    typedef enum logic [2:0] {
        SEL_PC   = 3'd0,
        SEL_SOUT = 3'd1,
        SEL_CALC = 3'd2,
        SEL_SP   = 3'd3,
        SEL_MDB  = 3'd4
    } sel_e;

    typedef enum logic [1:0] {
        FMT_DOUBLE = 2'd0,
        FMT_SINGLE = 2'd1,
        FMT_JUMP   = 2'd2,
        FMT_RETI   = 2'd3
    } fmt_e;

    state_e state_q, state_d;
    sel_e   sel_q, sel_d;
    logic   rd_q, rd_d;
    logic   wr_q, wr_d;
    logic   gate_q, gate_d;
    logic   busy_q, busy_d;
    logic   done_q, done_d;

    logic   rdy;
    logic   is_double;
    logic   is_push;
    logic   needs_wb;
    state_e after_src;
    state_e src_next;

`ifdef MAB_WAIT_STATE_EN
    assign rdy = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign rdy = 1'b1;
`endif

    assign is_double = (op_fmt == FMT_DOUBLE);
    assign is_push   = (op_fmt == FMT_SINGLE) && op_push;
    assign needs_wb  = (is_double && dst_mem) || ((op_fmt == FMT_SINGLE) && wb_mem);

    // Destination phase exists only for double-operand instructions.
    always_comb begin
        after_src = S_EXEC;
        if (is_double && dst_ext)
            after_src = S_DST_EXT;
        else if (is_double && dst_mem)
            after_src = S_DST_RD;
        src_next = src_mem ? S_SRC_RD : after_src;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (run) state_d = S_FETCH;
            S_FETCH:   if (rdy) state_d = S_DECODE;
            S_DECODE: begin
                if (op_fmt == FMT_JUMP)
                    state_d = S_EXEC;
                else if (op_fmt == FMT_RETI)
                    state_d = S_POP_SR;
                else if (src_ext)
                    state_d = S_SRC_EXT;
                else
                    state_d = src_next;
            end
            S_SRC_EXT: if (rdy) state_d = src_next;
            S_SRC_RD:  if (mem_rd && rdy) state_d = after_src;
            S_DST_EXT: if (rdy) state_d = dst_mem ? S_DST_RD : S_EXEC;
            S_DST_RD:  if (mem_rd && rdy) state_d = S_EXEC;
            S_EXEC: begin
                if (is_push)
                    state_d = S_PUSH_WR;
                else if (needs_wb)
                    state_d = S_DST_WR;
                else
                    state_d = S_DONE;
            end
            S_DST_WR:  if (rdy) state_d = S_DONE;
            S_PUSH_WR: if (rdy) state_d = S_DONE;
            S_POP_SR:  if (rdy) state_d = S_POP_PC;
            S_POP_PC:  if (rdy) state_d = S_DONE;
            S_DONE:    state_d = run ? S_FETCH : S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Registered outputs are decoded from the state being entered, so they line up with state_q.
    always_comb begin
        sel_d  = SEL_PC;
        rd_d   = 1'b0;
        wr_d   = 1'b0;
        gate_d = 1'b0;
        unique case (state_d)
            S_FETCH, S_SRC_EXT, S_DST_EXT: rd_d = 1'b1;
            S_SRC_RD: begin
                sel_d  = src_ind ? SEL_SOUT : SEL_CALC;
                rd_d   = 1'b1;
                gate_d = !src_ind;
            end
            S_DST_RD: begin
                sel_d  = SEL_CALC;
                rd_d   = 1'b1;
                gate_d = 1'b1;
            end
            S_DST_WR: begin
                sel_d = ((op_fmt == FMT_SINGLE) && src_ind) ? SEL_SOUT : SEL_CALC;
                wr_d  = 1'b1;
            end
            S_PUSH_WR: begin
                sel_d = SEL_SP;
                wr_d  = 1'b1;
            end
            S_POP_SR, S_POP_PC: begin
                sel_d = SEL_SP;
                rd_d  = 1'b1;
            end
            default: ;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            sel_q   <= SEL_PC;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            gate_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            gate_q  <= gate_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Reads addressed by CALC_out wait for the address calculator.
    assign mem_rd  = rd_q && (!gate_q || CALC_done);
    assign mem_wr  = wr_q;
    assign MAB_sel = sel_q;
    assign busy    = busy_q;
    assign done    = done_q;

    assign pc_inc  = rdy && ((state_q == S_FETCH) || (state_q == S_SRC_EXT) || (state_q == S_DST_EXT));
    assign ir_load = rdy && (state_q == S_FETCH);
    assign sp_inc  = rdy && ((state_q == S_POP_SR) || (state_q == S_POP_PC));
    assign sp_dec  = (state_q == S_EXEC) && is_push;

endmodule

// File: tb/tb_mab_access_ctrl.sv
// Randomized bench for mab_access_ctrl: instructions are expanded into per-cycle
// expected traces from their access list, then replayed in lockstep against the DUT.
module tb_mab_access_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic [1:0] op_fmt;
    logic       src_ext, src_mem, src_ind, dst_ext, dst_mem, wb_mem, op_push;
    logic       CALC_done, mem_ready;
    logic [2:0] MAB_sel;
    logic       mem_rd, mem_wr, pc_inc, sp_dec, sp_inc, ir_load, busy, done;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

`ifdef MAB_WAIT_STATE_EN
    localparam bit WS = 1'b1;
`else
    localparam bit WS = 1'b0;
`endif

    mab_access_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .op_fmt    (op_fmt),
        .src_ext   (src_ext),
        .src_mem   (src_mem),
        .src_ind   (src_ind),
        .dst_ext   (dst_ext),
        .dst_mem   (dst_mem),
        .wb_mem    (wb_mem),
        .op_push   (op_push),
        .CALC_done (CALC_done),
        .mem_ready (mem_ready),
        .MAB_sel   (MAB_sel),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .pc_inc    (pc_inc),
        .sp_dec    (sp_dec),
        .sp_inc    (sp_inc),
        .ir_load   (ir_load),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] sel;
        logic       rd, wr, pci, spd, spi, irl, busy, done;
        logic       ready, calc, run;
        logic [1:0] fmt;
        logic       sx, sm, si, dx, dm, wb, pu;
    } rec_t;

    rec_t q[$];
    rec_t cur;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic rbit();
        return $urandom_range(1, 0) != 0;
    endfunction

    function automatic logic [31:0] out_vec();
        return {22'd0, MAB_sel, mem_rd, mem_wr, pc_inc, sp_dec, sp_inc, ir_load, busy, done};
    endfunction

    function automatic logic [31:0] exp_vec(input rec_t r);
        return {22'd0, r.sel, r.rd, r.wr, r.pci, r.spd, r.spi, r.irl, r.busy, r.done};
    endfunction

    task automatic add(input logic [2:0] sel, input logic rd, input logic wr, input logic pci,
                       input logic spd, input logic spi, input logic irl, input logic dn,
                       input logic ready, input logic calc);
        rec_t r;
        r = cur;
        r.sel = sel; r.rd = rd; r.wr = wr; r.pci = pci; r.spd = spd; r.spi = spi;
        r.irl = irl; r.busy = 1'b1; r.done = dn; r.ready = ready; r.calc = calc;
        q.push_back(r);
    endtask

    task automatic idle(input logic run_v);
        rec_t r;
        r = cur;
        r.sel = 3'd0; r.rd = 0; r.wr = 0; r.pci = 0; r.spd = 0; r.spi = 0; r.irl = 0;
        r.busy = 0; r.done = 0; r.ready = rbit(); r.calc = rbit(); r.run = run_v;
        q.push_back(r);
    endtask

    // Cycle with no memory access (DECODE, EXEC, DONE).
    task automatic quiet(input logic spd, input logic dn);
        add(3'd0, 0, 0, 0, spd, 0, 0, dn, rbit(), rbit());
    endtask

    // kind: 0 plain, 1 pc step, 2 pc step + ir load, 3 sp step
    task automatic access(input logic [2:0] sel, input logic wr, input int unsigned kind, input logic gated);
        int unsigned c;
        int unsigned w;
        c = gated ? $urandom_range(3, 0) : 0;
        w = WS ? $urandom_range(2, 0) : 0;
        for (int unsigned i = 0; i < c; i++)
            add(sel, 0, 0, 0, 0, 0, 0, 0, rbit(), 0);
        for (int unsigned i = 0; i < w; i++)
            add(sel, !wr, wr, 0, 0, 0, 0, 0, 0, 1);
        add(sel, !wr, wr, (kind == 1) || (kind == 2), 0, kind == 3, kind == 2, 0,
            WS ? 1'b1 : rbit(), 1);
    endtask

    // bits = {src_ext, src_mem, src_ind, dst_ext, dst_mem, wb_mem, op_push}
    task automatic gen(input logic [1:0] fmt, input logic [6:0] bits, input logic stop);
        logic push;
        cur.fmt = fmt;
        {cur.sx, cur.sm, cur.si, cur.dx, cur.dm, cur.wb, cur.pu} = bits;
        cur.run = !stop;
        push = (fmt == 2'd1) && cur.pu;
        access(3'd0, 0, 2, 0);
        quiet(0, 0);
        if (fmt == 2'd2) begin
            quiet(0, 0);
            quiet(0, 1);
        end else if (fmt == 2'd3) begin
            access(3'd3, 0, 3, 0);
            access(3'd3, 0, 3, 0);
            quiet(0, 1);
        end else begin
            if (cur.sx) access(3'd0, 0, 1, 0);
            if (cur.sm) access(cur.si ? 3'd1 : 3'd2, 0, 0, !cur.si);
            if (fmt == 2'd0) begin
                if (cur.dx) access(3'd0, 0, 1, 0);
                if (cur.dm) access(3'd2, 0, 0, 1);
            end
            quiet(push, 0);
            if (push)
                access(3'd3, 1, 0, 0);
            else if (((fmt == 2'd0) && cur.dm) || ((fmt == 2'd1) && cur.wb))
                access(((fmt == 2'd1) && cur.si) ? 3'd1 : 3'd2, 1, 0, 0);
            quiet(0, 1);
        end
        if (stop) begin
            if (rbit()) idle(0);
            idle(1);
        end
    endtask

    task automatic drive(input rec_t r);
        run = r.run; op_fmt = r.fmt;
        src_ext = r.sx; src_mem = r.sm; src_ind = r.si;
        dst_ext = r.dx; dst_mem = r.dm; wb_mem = r.wb; op_push = r.pu;
        mem_ready = r.ready; CALC_done = r.calc;
    endtask

    initial begin
        rst = 1'b1; run = 1'b1; op_fmt = 2'd0;
        src_ext = 0; src_mem = 0; src_ind = 0; dst_ext = 0; dst_mem = 0; wb_mem = 0; op_push = 0;
        CALC_done = 0; mem_ready = 0;
        #12;
        check("reset_outs", out_vec(), 32'd0);

        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("fetch_rd", {31'd0, mem_rd}, 32'd1);
        check("fetch_busy", {31'd0, busy}, 32'd1);
        check("fetch_sel", {29'd0, MAB_sel}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_rd", {31'd0, mem_rd}, 32'd0);
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        check("async_rst_outs", out_vec(), 32'd0);

        @(negedge clk);
        run = 1'b0;
        rst = 1'b0;

        cur = '{sel: 3'd0, fmt: 2'd0, default: 1'b0};
        idle(1);
        gen(2'd0, 7'b0000000, 0);
        gen(2'd0, 7'b1100000, 0);
        gen(2'd0, 7'b1101100, 0);
        gen(2'd1, 7'b0000001, 0);
        gen(2'd3, 7'b0000000, 1);
        gen(2'd2, 7'b0000000, 0);
        gen(2'd1, 7'b0110010, 0);
        for (int i = 0; i < 200; i++)
            gen(2'($urandom_range(3, 0)), 7'($urandom_range(127, 0)), $urandom_range(7, 0) == 0);

        foreach (q[i]) begin
            @(posedge clk);
            #1;
            drive(q[i]);
            @(negedge clk);
            check($sformatf("cyc%0d", i), out_vec(), exp_vec(q[i]));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
